cdb_arbiter: RTL and testbench

Collects completed results from the execution units (ALU wrappers and future FUs) and serializes them onto a single common data bus (CDB). The CDB feeds reservation-station wakeup and ROB completion. Each FU gets a small FIFO, so results that lose arbitration are never dropped. Per-FU stall outputs tell issue logic when to stop dispatching to a unit. The block sits between the FU result ports and the CDB consumers.

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// FU result ports and common data bus of the CDB arbiter.
// The master drives FU results and flush; the slave drives stalls and the CDB.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 6
);
    localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*32-1:0]    fu_result;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic                    flush;
    logic [NUM_FU-1:0]       fu_stall;
    logic                    cdb_valid;
    logic [31:0]             cdb_data;
    logic [TAG_W-1:0]        cdb_tag;
    logic [SRC_W-1:0]        cdb_src;
    logic                    overflow;

    modport master (
        output fu_valid, fu_result, fu_tag, flush,
        input  fu_stall, cdb_valid, cdb_data, cdb_tag, cdb_src, overflow
    );

    modport slave (
        input  fu_valid, fu_result, fu_tag, flush,
        output fu_stall, cdb_valid, cdb_data, cdb_tag, cdb_src, overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Serializes FU results onto one CDB with per-FU FIFOs and round-robin grant.
// Empty FIFOs let a fresh result bypass straight to the bus.
module cdb_arbiter #(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + TAG_W;

    logic [ENT_W-1:0] mem [NUM_FU][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_FU];
    logic [PTR_W-1:0] wr_ptr [NUM_FU];
    logic [CNT_W-1:0] count  [NUM_FU];
    logic [SRC_W-1:0] rr_ptr;

    logic             cdb_valid;
    logic [31:0]      cdb_data;
    logic [TAG_W-1:0] cdb_tag;
    logic [SRC_W-1:0] cdb_src;
    logic             overflow;

    logic [31:0]      in_res [NUM_FU];
    logic [TAG_W-1:0] in_tag [NUM_FU];

    logic [NUM_FU-1:0] has_head;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] stall;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] wr_en;
    logic [NUM_FU-1:0] drop;

    logic             grant;
    logic [SRC_W-1:0] win;
    logic [SRC_W:0]   scan;
    logic             win_head;
    logic [ENT_W-1:0] win_ent;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign in_res[g] = bus.fu_result[32*g +: 32];
        assign in_tag[g] = bus.fu_tag[TAG_W*g +: TAG_W];
    end

    // Stall counts the result already in flight from a single-cycle FU.
    always_comb begin
        has_head = '0;
        cand     = '0;
        full     = '0;
        stall    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            has_head[i] = (count[i] != '0);
            cand[i]     = has_head[i] | bus.fu_valid[i];
            full[i]     = (count[i] == CNT_W'(DEPTH));
            stall[i]    = ({1'b0, count[i]}
                          + {{CNT_W{1'b0}}, bus.fu_valid[i]})
                          >= (CNT_W+1)'(DEPTH - 1);
        end
    end

    always_comb begin
        grant = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(NUM_FU))
                scan = scan - (SRC_W+1)'(NUM_FU);
            if (!grant && cand[scan[SRC_W-1:0]]) begin
                grant = 1'b1;
                win   = scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        win_head = has_head[win];
        if (win_head)
            win_ent = mem[win][rd_ptr[win]];
        else
            win_ent = {in_res[win], in_tag[win]};
    end

    // A bypassed winner never enters its FIFO; every other arrival does.
    always_comb begin
        pop   = '0;
        wr_en = '0;
        drop  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            logic mine;
            mine     = grant && (win == SRC_W'(i));
            pop[i]   = mine && has_head[i];
            wr_en[i] = bus.fu_valid[i] && !(mine && !has_head[i])
                       && !full[i];
            drop[i]  = bus.fu_valid[i] && !(mine && !has_head[i])
                       && full[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (wr_en[i])
                mem[i][wr_ptr[i]] <= {in_res[i], in_tag[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            cdb_src   <= '0;
            overflow  <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant;
            if (grant) begin
                cdb_data <= win_ent[ENT_W-1:TAG_W];
                cdb_tag  <= win_ent[TAG_W-1:0];
                cdb_src  <= win;
                if (win == SRC_W'(NUM_FU - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= win + SRC_W'(1);
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (wr_en[i])
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                unique case ({wr_en[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (|drop)
                overflow <= 1'b1;
        end
    end

    assign bus.fu_stall  = stall;
    assign bus.cdb_valid = cdb_valid;
    assign bus.cdb_data  = cdb_data;
    assign bus.cdb_tag   = cdb_tag;
    assign bus.cdb_src   = cdb_src;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model feeds
// expected broadcasts; an independent monitor checks the CDB every cycle.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int TW = 6;
    localparam int D  = 4;

    typedef struct {
        logic [31:0] d;
        logic [TW-1:0] t;
    } ent_t;

    typedef struct {
        int cyc;
        logic [31:0] d;
        logic [TW-1:0] t;
        int src;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(N), .TAG_W(TW)) bus ();

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    ent_t mq[N][$];
    int mrr = 0;
    bit movf = 1'b0;
    exp_t sb[$];
    logic [N-1:0] mstall;
    int seq[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: per-FU queues, round-robin over "has something to send".
    task automatic model_step(input logic [N-1:0] v,
                              input logic [N*32-1:0] r,
                              input logic [N*TW-1:0] t,
                              input logic fl, input logic rs);
        int win;
        bit byp;
        int sz0[N];
        ent_t e;
        exp_t x;
        if (rs) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mrr = 0;
            movf = 1'b0;
            return;
        end
        if (fl) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mrr = 0;
            return;
        end
        for (int i = 0; i < N; i++) sz0[i] = mq[i].size();
        win = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mrr + k) % N;
            if (win < 0 && (sz0[i] > 0 || v[i])) win = i;
        end
        byp = 1'b0;
        if (win >= 0) begin
            if (sz0[win] > 0) begin
                e = mq[win].pop_front();
            end else begin
                e.d = r[win*32 +: 32];
                e.t = t[win*TW +: TW];
                byp = 1'b1;
            end
            x.cyc = cyc + 1;
            x.d = e.d;
            x.t = e.t;
            x.src = win;
            sb.push_back(x);
            mrr = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && !(byp && i == win)) begin
                if (sz0[i] >= D) begin
                    movf = 1'b1;
                end else begin
                    e.d = r[i*32 +: 32];
                    e.t = t[i*TW +: TW];
                    mq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*32-1:0] r,
                         input logic [N*TW-1:0] t, input logic fl,
                         input logic rs);
        @(negedge clk);
        bus.fu_valid = v;
        bus.fu_result = r;
        bus.fu_tag = t;
        bus.flush = fl;
        rst = rs;
        #1;
        for (int i = 0; i < N; i++)
            mstall[i] = (mq[i].size() + int'(v[i])) >= D - 1;
        if (mon_en && !rs) chk("fu_stall", 64'(bus.fu_stall), 64'(mstall));
        model_step(v, r, t, fl, rs);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive('0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [N*32-1:0] rnd_res();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Single-cycle FUs: an issue granted while unstalled returns next cycle.
    task automatic run_obey(input int n, input logic [N-1:0] mask,
                            input int pct, input int fl_pct);
        logic [N-1:0] en;
        logic [N-1:0] v;
        logic [N*TW-1:0] t;
        en = '0;
        for (int c = 0; c <= n; c++) begin
            v = en;
            t = '0;
            for (int i = 0; i < N; i++) begin
                t[i*TW +: TW] = TW'(seq[i]);
                if (v[i]) seq[i]++;
            end
            drive(v, rnd_res(), t,
                  1'($urandom_range(99) < fl_pct), 1'b0);
            for (int i = 0; i < N; i++)
                en[i] = (c < n) && mask[i] && !mstall[i]
                        && ($urandom_range(99) < pct);
        end
    endtask

    task automatic run_free(input int n, input int pct, input int fl_pct,
                            input int rs_pct);
        logic [N-1:0] v;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) v[i] = $urandom_range(99) < pct;
            drive(v, rnd_res(), (N*TW)'($urandom),
                  1'($urandom_range(99) < fl_pct),
                  1'($urandom_range(99) < rs_pct));
        end
    endtask

    task automatic chk_reset_state();
        @(posedge clk);
        #2;
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 0);
        chk("rst_cdb_data", 64'(bus.cdb_data), 0);
        chk("rst_cdb_tag", 64'(bus.cdb_tag), 0);
        chk("rst_cdb_src", 64'(bus.cdb_src), 0);
        chk("rst_overflow", 64'(bus.overflow), 0);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                x = sb.pop_front();
                chk("stale_expect", 64'(x.cyc), 64'(cyc));
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                x = sb.pop_front();
                chk("cdb_valid", 64'(bus.cdb_valid), 1);
                if (bus.cdb_valid === 1'b1) begin
                    chk("cdb_data", 64'(bus.cdb_data), 64'(x.d));
                    chk("cdb_tag", 64'(bus.cdb_tag), 64'(x.t));
                    chk("cdb_src", 64'(bus.cdb_src), 64'(x.src));
                end
            end else begin
                chk("cdb_idle", 64'(bus.cdb_valid), 0);
            end
            chk("overflow", 64'(bus.overflow), 64'(movf));
        end
    end

    initial begin
        rst = 1'b1;
        bus.fu_valid = '0;
        bus.fu_result = '0;
        bus.fu_tag = '0;
        bus.flush = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = $urandom_range(63);

        drive('0, '0, '0, 1'b0, 1'b1);
        drive('0, '0, '0, 1'b0, 1'b1);
        mon_en = 1'b1;
        chk_reset_state();

        // single bypass from FU0
        drive(3'b001, {64'h0, 32'h0000_00AB}, {12'h0, 6'd5}, 1'b0, 1'b0);
        idle(2);

        // three-way collision from rr=0
        drive('0, '0, '0, 1'b1, 1'b0);
        drive(3'b111, rnd_res(), {6'd3, 6'd2, 6'd1}, 1'b0, 1'b0);
        idle(4);

        // FU0/FU1 fairness with stall obeyed
        drive('0, '0, '0, 1'b1, 1'b0);
        run_obey(8, 3'b011, 100, 0);
        idle(10);

        // FU2 ordering against a busy FU0
        seq[2] = 10;
        run_obey(24, 3'b101, 100, 0);
        idle(10);

        run_obey(300, 3'b111, 70, 2);
        idle(12);
        chk("no_ovf_obey", 64'(bus.overflow), 0);

        // flush discards buffered entries and same-cycle input
        drive(3'b111, rnd_res(), (N*TW)'($urandom), 1'b0, 1'b0);
        drive(3'b111, rnd_res(), (N*TW)'($urandom), 1'b0, 1'b0);
        drive(3'b111, rnd_res(), (N*TW)'($urandom), 1'b0, 1'b0);
        drive(3'b010, rnd_res(), (N*TW)'($urandom), 1'b1, 1'b0);
        idle(3);

        // overflow with stall ignored, sticky through flush
        for (int c = 0; c < 10; c++)
            drive(3'b011, rnd_res(), (N*TW)'($urandom), 1'b0, 1'b0);
        drive('0, '0, '0, 1'b1, 1'b0);
        idle(2);
        chk("ovf_sticky", 64'(bus.overflow), 1);

        // reset mid-operation beats flush and inputs
        drive(3'b111, rnd_res(), (N*TW)'($urandom), 1'b1, 1'b1);
        chk_reset_state();

        run_free(400, 50, 2, 1);
        idle(14);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
